sequence_transmitter: RTL and testbench

Serial pattern generator driving the single-bit W line consumed by the Moore sequence-detector controllers. It loads a WIDTH-bit pattern on a start strobe and shifts it out MSB-first, one bit per clock. Between repetitions it inserts a fixed idle gap, and it can repeat the frame a programmed number of times. It is the stimulus/transmit end of the W/Z detector link and is synthesizable.

---
 rtl/sequence_transmitter_pkg.sv | 15 +
 rtl/pattern_shifter.sv | 24 ++
 rtl/sequence_transmitter.sv | 120 ++++++++++++
 tb/tb_sequence_transmitter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sequence_transmitter_pkg.sv
// Shared controller package: FSM state encoding for the W/Z link, also used by
// the detector bench.
package sequence_transmitter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SHIFT = 3'b001,
    GAP   = 3'b010,
    DONE  = 3'b011
  } tx_state_e;

  localparam int GAP_CNT_W = 4;
  localparam int REP_CNT_W = 4;

endpackage

// File: rtl/pattern_shifter.sv
// WIDTH-bit load / shift-left register with MSB output and async active-low clear.
module pattern_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  // Load wins over shift so a frame reload can coincide with the last bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     sr_q <= '0;
    else if (load_i)  sr_q <= data_i;
    else if (shift_i) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/sequence_transmitter.sv
// Serial pattern generator: sends a WIDTH-bit pattern MSB-first on outputW,
// with an idle gap after every frame and a programmable repeat count.
module sequence_transmitter
  import sequence_transmitter_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             inputClk,
  input  logic             inputReset,
  input  logic             inputStart,
  input  logic [WIDTH-1:0] inputData,
  input  logic [3:0]       inputRepeat,
  output logic             outputW,
  output logic             outputBusy,
  output logic             outputDone
);

  localparam int                   BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]        BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  tx_state_e              state_q, state_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic [REP_CNT_W-1:0]   rep_q, rep_d;
  logic [WIDTH-1:0]       pat_q, pat_d;

  logic             sh_load, sh_shift, sh_msb;
  logic [WIDTH-1:0] sh_data;

  pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk_i   (inputClk),
    .rst_n_i (inputReset),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .msb_o   (sh_msb)
  );

  always_ff @(posedge inputClk or negedge inputReset) begin
    if (!inputReset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    pat_d    = pat_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = pat_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (inputStart) begin
          pat_d   = inputData;
          rep_d   = inputRepeat;
          bit_d   = BIT_LAST;
          sh_data = inputData;
          sh_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_shift = 1'b1;
        bit_d    = bit_q - 1'b1;
        if (bit_q == '0) begin
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LAST;
            state_d = GAP;
          end else if (rep_q != '0) begin
            // End of frame with no gap: reload from the captured copy.
            rep_d   = rep_q - 1'b1;
            bit_d   = BIT_LAST;
            sh_load = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == '0) begin
          gap_d = '0;
          if (rep_q != '0) begin
            rep_d   = rep_q - 1'b1;
            bit_d   = BIT_LAST;
            sh_load = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign outputW    = (state_q == SHIFT) ? sh_msb : IDLE_LEVEL;
  assign outputBusy = (state_q == SHIFT) || (state_q == GAP);
  assign outputDone = (state_q == DONE);

endmodule

// File: tb/tb_sequence_transmitter.sv
// Directed bench for sequence_transmitter: reset, single/repeat frames, ignored
// inputs, back-to-back start and a GAP_CYCLES=0 loopback into a window detector.
module tb_sequence_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start0 = 1'b0;
  logic [3:0] data = '0, data0 = '0;
  logic [3:0] rpt = '0, rpt0 = '0;
  logic       w, busy, done;
  logic       w0, busy0, done0;
  logic [3:0] hist;
  logic       z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequence_transmitter #(.WIDTH(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut (
    .inputClk(clk), .inputReset(rst_n), .inputStart(start), .inputData(data),
    .inputRepeat(rpt), .outputW(w), .outputBusy(busy), .outputDone(done)
  );

  sequence_transmitter #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .inputClk(clk), .inputReset(rst_n), .inputStart(start0), .inputData(data0),
    .inputRepeat(rpt0), .outputW(w0), .outputBusy(busy0), .outputDone(done0)
  );

  // Moore detector for 1011 on the gapless link.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= '0;
    else        hist <= {hist[2:0], w0};
  assign z = (hist == 4'b1011);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns #1 into the first pattern-bit cycle.
  task automatic kick(input logic [3:0] d, input logic [3:0] r);
    data  = d;
    rpt   = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks one frame of 4 bits + 2 gap cycles, starting in the first bit cycle.
  task automatic frame(input string tag, input logic [3:0] d);
    logic [5:0] exp_w;
    exp_w = {d, 2'b00};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_w%0d", tag, i), w, exp_w[5-i]);
      check($sformatf("%s_busy%0d", tag, i), busy, 1);
      check($sformatf("%s_done%0d", tag, i), done, 0);
      tick();
    end
  endtask

  initial begin
    int zc;
    // Reset held 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_w", w, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Single frame 1011
    kick(4'b1011, 4'd0);
    frame("single", 4'b1011);
    check("single_done", done, 1);
    check("single_done_busy", busy, 0);
    check("single_done_w", w, 0);
    tick();
    check("single_done_clr", done, 0);
    check("single_idle_busy", busy, 0);

    // Repeats: 0110 x3, data changed after start must not matter
    kick(4'b0110, 4'd2);
    data = 4'b1111;
    rpt  = 4'd9;
    for (int f = 0; f < 3; f++) frame($sformatf("rep%0d", f), 4'b0110);
    check("rep_done", done, 1);
    tick();
    check("rep_done_once", done, 0);
    check("rep_idle", busy, 0);

    // Start + data change mid-frame are ignored
    kick(4'b1011, 4'd0);
    tick();
    check("ign_w0", w, 0);
    start = 1'b1;
    data  = 4'b1111;
    tick();
    start = 1'b0;
    check("ign_w1", w, 1);
    tick();
    check("ign_w2", w, 1);
    tick();
    check("ign_gap0", w, 0);
    tick();
    check("ign_gap1", w, 0);
    tick();
    check("ign_done", done, 1);
    tick();
    check("ign_no_second_busy", busy, 0);
    check("ign_no_second_w", w, 0);

    // Back-to-back: start during DONE
    kick(4'b1011, 4'd0);
    repeat (6) tick();
    check("b2b_done", done, 1);
    data  = 4'b1001;
    start = 1'b1;
    tick();
    start = 1'b0;
    frame("b2b", 4'b1001);
    check("b2b_done2", done, 1);
    tick();

    // Async reset mid-frame
    kick(4'b1011, 4'd3);
    check("mid_w_before", w, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_w", w, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_w", w, 0);
    check("post_rst_done", done, 0);

    // Loopback, GAP_CYCLES=0: 1011 1011 into the detector
    repeat (4) tick();
    data0  = 4'b1011;
    rpt0   = 4'd1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("lb_busy", busy0, 1);
    repeat (4) tick();
    check("lb_z_first", z, 1);
    tick();
    check("lb_z_between", z, 0);
    repeat (3) tick();
    check("lb_z_second", z, 1);
    check("lb_done", done0, 1);
    check("lb_done_busy", busy0, 0);

    // Non-matching 0000 never raises Z
    repeat (5) tick();
    data0  = 4'b0000;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    zc = 0;
    for (int i = 0; i < 12; i++) begin
      if (z) zc++;
      tick();
    end
    check("lb_zero_noz", zc, 0);
    check("lb_zero_idle", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
